// File: rtl/dmem_sb_if.sv
// Core data port and memory bus bundle for dmem_store_buffer.
// slave = store buffer view, master = core/bus-side view (driver of the
// core requests and of the bus responses).
interface dmem_sb_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              memwrite;
  logic              memread;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              stall;
  logic              sb_empty;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_gnt;
  logic              bus_rvalid;
  logic [DATA_W-1:0] bus_rdata;

  modport slave (
    input  memwrite, memread, addr, writedata, bus_gnt, bus_rvalid, bus_rdata,
    output readdata, stall, sb_empty, bus_req, bus_we, bus_addr, bus_wdata
  );

  modport master (
    output memwrite, memread, addr, writedata, bus_gnt, bus_rvalid, bus_rdata,
    input  readdata, stall, sb_empty, bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-store buffer between the core data port and a req/gnt/rvalid bus.
// Stores are queued and drained in the background; loads either forward from
// the youngest matching queued store or go out as a bus read.
// Optional feature macro: DMEM_SB_FWD_EN
//   defined   : store-to-load forwarding, a load miss is issued ahead of drains
//   undefined : no comparators, every load waits for an empty buffer and idle bus
module dmem_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic      clk,
  input logic      reset,
  dmem_sb_if.slave sb
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int WA_W  = ADDR_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_WR_REQ  = 2'b01,
    ST_RD_REQ  = 2'b10,
    ST_RD_WAIT = 2'b11
  } state_t;

  state_t            r_state;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [WA_W-1:0]   r_wa [DEPTH];
  logic [DATA_W-1:0] r_wd [DEPTH];
  logic              r_bus_req;
  logic              r_bus_we;
  logic [ADDR_W-1:0] r_bus_addr;
  logic [DATA_W-1:0] r_bus_wdata;
  logic              r_sb_empty;

  logic [WA_W-1:0]   w_ld_wa;
  logic              w_store;
  logic              w_load;
  logic              w_pop;
  logic              w_push;
  logic              w_rd_done;
  logic              w_hit;
  logic [DATA_W-1:0] w_hit_data;
  logic              w_rd_go;
  logic [CNT_W-1:0]  w_count_nxt;
  logic [PTR_W-1:0]  w_head_nxt;
  logic              w_unused_addr_lsb;

  assign w_ld_wa           = sb.addr[ADDR_W-1:2];
  assign w_unused_addr_lsb = ^sb.addr[1:0];
  // A simultaneous store and load is a store.
  assign w_store    = sb.memwrite;
  assign w_load     = sb.memread & ~sb.memwrite;
  assign w_pop      = (r_state == ST_WR_REQ) & sb.bus_gnt;
  // A full buffer still takes a store when the head leaves in the same cycle.
  assign w_push     = w_store & ((r_count != CNT_W'(DEPTH)) | w_pop);
  assign w_rd_done  = (r_state == ST_RD_WAIT) & sb.bus_rvalid;
  assign w_head_nxt = r_head + PTR_W'(1);

`ifdef DMEM_SB_FWD_EN
  // Oldest-to-youngest scan of valid entries so the youngest match wins.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CNT_W'(k) < r_count) && (r_wa[r_head + PTR_W'(k)] == w_ld_wa)) begin
        w_hit      = 1'b1;
        w_hit_data = r_wd[r_head + PTR_W'(k)];
      end else begin
        w_hit      = w_hit;
        w_hit_data = w_hit_data;
      end
    end
  end

  // A miss cannot alias any queued store, so it may bypass the drain.
  assign w_rd_go = w_load & ~w_hit;
`else
  // Without comparators nothing is ever forwarded.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
  end

  // Loads are ordered behind every queued store.
  assign w_rd_go = w_load & (r_count == CNT_W'(0));
`endif

  // Occupancy after this cycle's push/pop.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  assign sb.readdata  = w_rd_done ? sb.bus_rdata : ((w_load & w_hit) ? w_hit_data : '0);
  assign sb.stall     = (w_store & ~w_push) | (w_load & ~(w_hit | w_rd_done));
  assign sb.sb_empty  = r_sb_empty;
  assign sb.bus_req   = r_bus_req;
  assign sb.bus_we    = r_bus_we;
  assign sb.bus_addr  = r_bus_addr;
  assign sb.bus_wdata = r_bus_wdata;

  // FIFO storage, pointers and the bus FSM with its registered bus outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_sb_empty  <= 1'b1;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_wdata <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_wa[i] <= '0;
        r_wd[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_wa[r_tail] <= w_ld_wa;
        r_wd[r_tail] <= sb.writedata;
        r_tail       <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= w_head_nxt;
      end
      r_count    <= w_count_nxt;
      r_sb_empty <= (w_count_nxt == CNT_W'(0));

      case (r_state)
        ST_IDLE: begin
          if (w_rd_go) begin
            r_state    <= ST_RD_REQ;
            r_bus_req  <= 1'b1;
            r_bus_we   <= 1'b0;
            r_bus_addr <= {w_ld_wa, 2'b00};
          end else if (r_count != CNT_W'(0)) begin
            r_state     <= ST_WR_REQ;
            r_bus_req   <= 1'b1;
            r_bus_we    <= 1'b1;
            r_bus_addr  <= {r_wa[r_head], 2'b00};
            r_bus_wdata <= r_wd[r_head];
          end
        end
        ST_WR_REQ: begin
          if (sb.bus_gnt) begin
            if (w_rd_go) begin
              r_state    <= ST_RD_REQ;
              r_bus_req  <= 1'b1;
              r_bus_we   <= 1'b0;
              r_bus_addr <= {w_ld_wa, 2'b00};
            end else if (r_count > CNT_W'(1)) begin
              // Back-to-back drain of the next entry.
              r_bus_req   <= 1'b1;
              r_bus_we    <= 1'b1;
              r_bus_addr  <= {r_wa[w_head_nxt], 2'b00};
              r_bus_wdata <= r_wd[w_head_nxt];
            end else begin
              r_state   <= ST_IDLE;
              r_bus_req <= 1'b0;
              r_bus_we  <= 1'b0;
            end
          end
        end
        ST_RD_REQ: begin
          if (sb.bus_gnt) begin
            r_state   <= ST_RD_WAIT;
            r_bus_req <= 1'b0;
          end
        end
        ST_RD_WAIT: begin
          if (sb.bus_rvalid) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_bus_req <= 1'b0;
          r_bus_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Directed testbench for dmem_store_buffer (DEPTH=4, 32-bit address/data).
// Expectations follow DMEM_SB_FWD_EN when the macro is defined.
module tb_dmem_store_buffer;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  int          rd_cnt;

  dmem_sb_if #(.ADDR_W(32), .DATA_W(32)) sbi ();

  dmem_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sbi)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Log every granted bus transfer, sampled mid-cycle.
  initial rd_cnt = 0;
  always @(negedge clk) begin
    if (reset && sbi.bus_req && sbi.bus_gnt) begin
      if (sbi.bus_we) begin
        wq_addr.push_back(sbi.bus_addr);
        wq_data.push_back(sbi.bus_wdata);
      end else begin
        rd_cnt = rd_cnt + 1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Grant everything until the buffer is empty and the bus idle.
  task automatic drain_all(input string tag);
    logic done;
    done = 1'b0;
    sbi.bus_gnt = 1'b1;
    for (int c = 0; c < 30; c++) begin
      #1;
      if (sbi.sb_empty && !sbi.bus_req) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check_eq(tag, {63'd0, done}, 64'd1);
    sbi.bus_gnt = 1'b0;
    tick();
  endtask

  initial begin
    int          wb;
    int          rb;
    int          stall_cnt;
    logic        done;
    logic        rg;
    logic        rd_empty;
    logic [31:0] rd_addr;
    logic [31:0] rd_val;

    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    sbi.memwrite   = 1'b0;
    sbi.memread    = 1'b0;
    sbi.addr       = 32'h0;
    sbi.writedata  = 32'h0;
    sbi.bus_gnt    = 1'b0;
    sbi.bus_rvalid = 1'b1;
    sbi.bus_rdata  = 32'hFFFF_FFFF;

    // Reset held two cycles with a stray rvalid.
    tick();
    tick();
    check_eq("rst_bus_req",   {63'd0, sbi.bus_req},   64'd0);
    check_eq("rst_bus_we",    {63'd0, sbi.bus_we},    64'd0);
    check_eq("rst_bus_addr",  {32'd0, sbi.bus_addr},  64'd0);
    check_eq("rst_bus_wdata", {32'd0, sbi.bus_wdata}, 64'd0);
    check_eq("rst_stall",     {63'd0, sbi.stall},     64'd0);
    check_eq("rst_sb_empty",  {63'd0, sbi.sb_empty},  64'd1);
    check_eq("rst_readdata",  {32'd0, sbi.readdata},  64'd0);
    reset = 1'b1;
    sbi.bus_rvalid = 1'b0;
    tick();

    // Posted stores with the bus refusing grants.
    wb = wq_addr.size();
    for (int i = 0; i < 4; i++) begin
      sbi.memwrite  = 1'b1;
      sbi.addr      = 32'h100 + 32'(4 * i);
      sbi.writedata = 32'hA0 + 32'(i);
      #1;
      check_eq($sformatf("st_acc%0d", i), {63'd0, sbi.stall}, 64'd0);
      tick();
    end
    sbi.addr      = 32'h110;
    sbi.writedata = 32'hA4;
    #1;
    check_eq("st_full_stall", {63'd0, sbi.stall}, 64'd1);
    tick();
    check_eq("st_full_hold",  {63'd0, sbi.stall},   64'd1);
    check_eq("st_head_req",   {63'd0, sbi.bus_req}, 64'd1);
    check_eq("st_head_we",    {63'd0, sbi.bus_we},  64'd1);
    check_eq("st_head_addr",  {32'd0, sbi.bus_addr}, 64'h100);
    sbi.bus_gnt = 1'b1;
    #1;
    check_eq("st_deq_acc", {63'd0, sbi.stall}, 64'd0);
    tick();
    sbi.memwrite = 1'b0;
    drain_all("st_drain_done");
    check_eq("st_wr_count", 64'(wq_addr.size() - wb), 64'd5);
    for (int i = 0; i < 5; i++) begin
      if (wb + i < wq_addr.size()) begin
        check_eq($sformatf("st_wr_addr%0d", i), {32'd0, wq_addr[wb + i]}, 64'h100 + 64'(4 * i));
        check_eq($sformatf("st_wr_data%0d", i), {32'd0, wq_data[wb + i]}, 64'hA0 + 64'(i));
      end
    end

    // Two stores to one word, then a load of that word.
    wb = wq_addr.size();
    rb = rd_cnt;
    sbi.memwrite  = 1'b1;
    sbi.addr      = 32'h200;
    sbi.writedata = 32'h11;
    tick();
    sbi.writedata = 32'h22;
    tick();
    sbi.memwrite = 1'b0;
    sbi.memread  = 1'b1;
    sbi.addr     = 32'h202;
`ifdef DMEM_SB_FWD_EN
    #1;
    check_eq("fwd_stall", {63'd0, sbi.stall},    64'd0);
    check_eq("fwd_data",  {32'd0, sbi.readdata}, 64'h22);
    tick();
    sbi.memread = 1'b0;
    drain_all("fwd_drain_done");
    check_eq("fwd_no_read", 64'(rd_cnt - rb), 64'd0);
`else
    sbi.bus_gnt = 1'b1;
    sbi.bus_rdata = 32'h5555_AAAA;
    done = 1'b0;
    rg = 1'b0;
    rd_empty = 1'b0;
    rd_addr = 32'h0;
    rd_val = 32'h0;
    for (int c = 0; c < 30; c++) begin
      sbi.bus_rvalid = rg;
      #1;
      if (!sbi.stall) begin
        done = 1'b1;
        rd_val = sbi.readdata;
        break;
      end
      if (sbi.bus_req && !sbi.bus_we) begin
        rg = 1'b1;
        rd_addr = sbi.bus_addr;
        rd_empty = sbi.sb_empty;
      end
      tick();
    end
    check_eq("nofwd_done",     {63'd0, done},     64'd1);
    check_eq("nofwd_empty",    {63'd0, rd_empty}, 64'd1);
    check_eq("nofwd_rd_addr",  {32'd0, rd_addr},  64'h200);
    check_eq("nofwd_readdata", {32'd0, rd_val},   64'h5555_AAAA);
    tick();
    sbi.bus_rvalid = 1'b0;
    sbi.memread = 1'b0;
    drain_all("nofwd_drain_done");
    check_eq("nofwd_one_read", 64'(rd_cnt - rb), 64'd1);
`endif
    check_eq("fwd_wr_count", 64'(wq_addr.size() - wb), 64'd2);
    if (wb + 1 < wq_addr.size()) begin
      check_eq("fwd_wr0_data", {32'd0, wq_data[wb]},     64'h11);
      check_eq("fwd_wr1_data", {32'd0, wq_data[wb + 1]}, 64'h22);
      check_eq("fwd_wr1_addr", {32'd0, wq_addr[wb + 1]}, 64'h200);
    end

    // Load miss: grant three cycles in, data three cycles after grant.
    sbi.memread = 1'b1;
    sbi.addr = 32'h300;
    sbi.bus_rdata = 32'hDEAD_BEEF;
    stall_cnt = 0;
    done = 1'b0;
    rd_val = 32'h0;
    for (int k = 0; k < 20; k++) begin
      sbi.bus_gnt = (k == 3);
      sbi.bus_rvalid = (k == 6);
      #1;
      if (k == 1) begin
        check_eq("miss_req",  {63'd0, sbi.bus_req},  64'd1);
        check_eq("miss_we",   {63'd0, sbi.bus_we},   64'd0);
        check_eq("miss_addr", {32'd0, sbi.bus_addr}, 64'h300);
      end
      if (!sbi.stall) begin
        done = 1'b1;
        rd_val = sbi.readdata;
        break;
      end
      stall_cnt = stall_cnt + 1;
      tick();
    end
    check_eq("miss_done",      {63'd0, done},   64'd1);
    check_eq("miss_stall_cyc", 64'(stall_cnt),  64'd6);
    check_eq("miss_readdata",  {32'd0, rd_val}, 64'hDEAD_BEEF);
    tick();
    sbi.memread = 1'b0;
    sbi.bus_gnt = 1'b0;
    sbi.bus_rvalid = 1'b0;
    tick();

    // Full buffer takes a store in the cycle the head is granted.
    wb = wq_addr.size();
    for (int i = 0; i < 4; i++) begin
      sbi.memwrite  = 1'b1;
      sbi.addr      = 32'h400 + 32'(4 * i);
      sbi.writedata = 32'hB0 + 32'(i);
      tick();
    end
    sbi.addr      = 32'h410;
    sbi.writedata = 32'hB4;
    sbi.bus_gnt   = 1'b1;
    #1;
    check_eq("fulldq_stall", {63'd0, sbi.stall}, 64'd0);
    tick();
    sbi.bus_gnt   = 1'b0;
    sbi.addr      = 32'h414;
    sbi.writedata = 32'hB5;
    #1;
    check_eq("fulldq_still_full", {63'd0, sbi.stall}, 64'd1);
    sbi.memwrite = 1'b0;
    drain_all("fulldq_drain_done");
    check_eq("fulldq_wr_count", 64'(wq_addr.size() - wb), 64'd5);
    if (wb + 4 < wq_addr.size()) begin
      check_eq("fulldq_last_addr", {32'd0, wq_addr[wb + 4]}, 64'h410);
      check_eq("fulldq_last_data", {32'd0, wq_data[wb + 4]}, 64'hB4);
    end

    // Reset while a read is outstanding, then a late rvalid.
    sbi.memread = 1'b1;
    sbi.addr = 32'h500;
    tick();
    sbi.bus_gnt = 1'b1;
    tick();
    sbi.bus_gnt = 1'b0;
    #1;
    check_eq("rdw_stall", {63'd0, sbi.stall}, 64'd1);
    reset = 1'b0;
    sbi.memread = 1'b0;
    tick();
    reset = 1'b1;
    sbi.bus_rvalid = 1'b1;
    sbi.bus_rdata = 32'h1234_5678;
    #1;
    check_eq("rstrd_stall",    {63'd0, sbi.stall},    64'd0);
    check_eq("rstrd_bus_req",  {63'd0, sbi.bus_req},  64'd0);
    check_eq("rstrd_readdata", {32'd0, sbi.readdata}, 64'd0);
    tick();
    sbi.bus_rvalid = 1'b0;
    #1;
    check_eq("rstrd_req_after", {63'd0, sbi.bus_req},  64'd0);
    check_eq("rstrd_empty",     {63'd0, sbi.sb_empty}, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
